apb_cfg_master: RTL and testbench

//  APB initiator that converts a single-outstanding valid/ready command stream into APB transfers.

---
 rtl/apb_cfg_master.sv | 174 +++++++++++++++++
 tb/tb_apb_cfg_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_master.sv
// apb_cfg_master: single-outstanding APB initiator.
// Converts a valid/ready command stream into APB transfers and returns
// read data / error status on a valid/ready response stream.
// Optional build macro: APB_MASTER_TIMEOUT_EN adds an ACCESS-phase wait
// timeout of TIMEOUT_CYCLES pready-low cycles, reported as an error response.
module apb_cfg_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_reg,     state_next;
  logic                    psel_reg,      psel_next;
  logic                    penable_reg,   penable_next;
  logic                    pwrite_reg,    pwrite_next;
  logic [ADDR_WIDTH-1:0]   paddr_reg,     paddr_next;
  logic [DATA_WIDTH-1:0]   pwdata_reg,    pwdata_next;
  logic                    rsp_vld_reg,   rsp_vld_next;
  logic                    rsp_err_reg,   rsp_err_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;

  // Byte-lane bits of the command address never reach the bus (word aligned).
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr[1:0];

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Value of the wait counter during the last permitted pready-low cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
`endif

  // Command is only taken while idle and out of reset.
  assign cmd_rdy   = (state_reg == IDLE) && presetn;

  assign psel      = psel_reg;
  assign penable   = penable_reg;
  assign pwrite    = pwrite_reg;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign rsp_vld   = rsp_vld_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

  // State and registered-output update; reset abandons any transfer.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_vld_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_vld_reg   <= rsp_vld_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_vld_next   = rsp_vld_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_rdata_next = rsp_rdata_reg;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (cmd_vld) begin
          pwrite_next  = cmd_write;
          paddr_next   = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          pwdata_next  = cmd_write ? cmd_wdata : '0;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          state_next   = SETUP;
        end
      end

      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end

      ACCESS: begin
        if (pready) begin
          // Completion: pready wins even on the final permitted cycle.
          rsp_err_next   = pslverr;
          rsp_rdata_next = (!pwrite_reg && !pslverr) ? prdata : '0;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_vld_next   = 1'b1;
          state_next     = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_reg == CNT_LAST) begin
          // Slave never answered: close the bus and report an error.
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_vld_next   = 1'b1;
          state_next     = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
`endif
      end

      RESP: begin
        if (rsp_rdy) begin
          rsp_vld_next = 1'b0;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Testbench for apb_cfg_master: directed plus randomized transfers checked
// against a word-addressed memory model and the transfer timing rules.
module tb_apb_cfg_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Expected contents of the slave (indexed by word-aligned byte address).
  logic [31:0] ref_mem   [logic [31:0]];
  // Contents the bench's APB slave actually holds, filled from bus traffic.
  logic [31:0] slave_mem [logic [31:0]];

  apb_cfg_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
  endfunction

  // One complete transfer from command to response handshake, checked each cycle.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input bit slverr, input int rsp_wait,
                         input bit queue_next);
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    int pen_cnt;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_wdata = wr ? wdata : 32'h0;
    exp_rdata = (!wr && !slverr) ? ref_read(exp_addr) : 32'h0;
    if (wr && !slverr) ref_mem[exp_addr] = wdata;

    chk("idle_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
    cmd_vld = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    step();
    // Scramble command inputs: the bus must use the latched values.
    cmd_vld = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_psel",    {31'b0, psel},    32'd1);
    chk("setup_penable", {31'b0, penable}, 32'd0);
    chk("setup_paddr",   paddr,            exp_addr);
    chk("setup_pwrite",  {31'b0, pwrite},  {31'b0, wr});
    chk("setup_pwdata",  pwdata,           exp_wdata);
    chk("setup_cmd_rdy", {31'b0, cmd_rdy}, 32'd0);
    step();

    pen_cnt = 0;
    for (int i = 0; i <= waits; i++) begin
      chk("access_psel",  {31'b0, psel}, 32'd1);
      chk("access_paddr", paddr,         exp_addr);
      chk("access_pwdata", pwdata,       exp_wdata);
      if (penable === 1'b1) pen_cnt++;
      pready  = (i == waits);
      pslverr = (i == waits) ? slverr : 1'($urandom);
      prdata  = (i == waits) ? slave_read(paddr) : $urandom;
      if (i == waits && pwrite === 1'b1 && !slverr) slave_mem[paddr] = pwdata;
      step();
    end
    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;

    chk("penable_cycles", pen_cnt,                   waits + 1);
    chk("rsp_vld_rise",   {31'b0, rsp_vld},          32'd1);
    chk("rsp_psel_low",   {31'b0, psel},             32'd0);
    chk("rsp_penable_low",{31'b0, penable},          32'd0);
    chk("rsp_err",        {31'b0, rsp_err},          {31'b0, slverr});
    chk("rsp_rdata",      rsp_rdata,                 exp_rdata);

    if (queue_next) cmd_vld = 1'b1;
    for (int i = 0; i < rsp_wait; i++) begin
      rsp_rdy = 1'b0;
      pready  = 1'($urandom);
      step();
      chk("hold_rsp_vld",   {31'b0, rsp_vld}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata,        exp_rdata);
      chk("hold_rsp_err",   {31'b0, rsp_err}, {31'b0, slverr});
      chk("hold_cmd_rdy",   {31'b0, cmd_rdy}, 32'd0);
      chk("hold_psel",      {31'b0, psel},    32'd0);
    end
    pready  = 1'b0;
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    chk("post_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("post_no_accept_psel", {31'b0, psel}, 32'd0);
    chk("post_paddr_kept",  paddr,  exp_addr);
    chk("post_pwdata_kept", pwdata, exp_wdata);
    chk("post_pwrite_kept", {31'b0, pwrite}, {31'b0, wr});
    cmd_vld = 1'b0;
    txn_no++;
    $display("txn %0d wr=%0b addr=%h wdata=%h waits=%0d slverr=%0b rsp_wait=%0d -> rdata=%h err=%0b",
             txn_no, wr, addr, wdata, waits, slverr, rsp_wait, exp_rdata, slverr);
  endtask

  initial begin
    logic [31:0] exp_rd;
    presetn = 1'b0; cmd_vld = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_rdy = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_psel",      {31'b0, psel},    32'd0);
    chk("rst_penable",   {31'b0, penable}, 32'd0);
    chk("rst_pwrite",    {31'b0, pwrite},  32'd0);
    chk("rst_rsp_vld",   {31'b0, rsp_vld}, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rst_paddr",     paddr,            32'h0);
    chk("rst_pwdata",    pwdata,           32'h0);
    chk("rst_rsp_rdata", rsp_rdata,        32'h0);
    chk("rst_cmd_rdy",   {31'b0, cmd_rdy}, 32'd0);
    presetn = 1'b1;
    #1;
    chk("rel_cmd_rdy",   {31'b0, cmd_rdy}, 32'd1);
    step();

    // Zero-wait write with unaligned address
    run_txn(1'b1, 32'h0000_0007, 32'hA5A5_0001, 0, 1'b0, 0, 1'b0);
    // Seed a value, then read it back through 3 wait states
    run_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 1, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 3, 1'b0, 0, 1'b0);
    // Read with slave error
    run_txn(1'b0, 32'h0000_0004, 32'h0, 2, 1'b1, 0, 1'b0);
    // Response back-pressure with a queued command, then the queued command
    run_txn(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0, 5, 1'b1);
    run_txn(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 0, 1'b0, 0, 1'b0);

    // Reset during ACCESS abandons the transfer
    cmd_vld = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    step();
    cmd_vld = 1'b0;
    step();
    pready = 1'b0;
    step();
    chk("pre_rst_penable", {31'b0, penable}, 32'd1);
    presetn = 1'b0;
    step();
    chk("midrst_psel",    {31'b0, psel},    32'd0);
    chk("midrst_penable", {31'b0, penable}, 32'd0);
    chk("midrst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("midrst_paddr",   paddr,            32'h0);
    chk("midrst_cmd_rdy", {31'b0, cmd_rdy}, 32'd0);
    presetn = 1'b1; pready = 1'b1; rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_no_rsp",  {31'b0, rsp_vld}, 32'd0);
      chk("after_rst_no_psel", {31'b0, psel},    32'd0);
    end
    pready = 1'b0; rsp_rdy = 1'b0;
    run_txn(1'b0, 32'h0000_0020, 32'h0, 1, 1'b0, 1, 1'b0);

    // Randomized traffic over a small address window
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), $urandom & 32'h3F, $urandom, int'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Slave that never raises pready
    cmd_vld = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
    step();
    cmd_vld = 1'b0;
    step();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_penable", {31'b0, penable}, 32'd1);
      pready = 1'b0;
      step();
    end
    chk("to_rsp_vld",   {31'b0, rsp_vld}, 32'd1);
    chk("to_rsp_err",   {31'b0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata,        32'h0);
    chk("to_psel",      {31'b0, psel},    32'd0);
`else
    for (int i = 0; i < 40; i++) begin
      chk("stuck_psel",    {31'b0, psel},    32'd1);
      chk("stuck_penable", {31'b0, penable}, 32'd1);
      chk("stuck_no_rsp",  {31'b0, rsp_vld}, 32'd0);
      pready = 1'b0;
      step();
    end
    exp_rd = ref_read(32'h0000_0030);
    pready = 1'b1; pslverr = 1'b0; prdata = slave_read(paddr);
    step();
    pready = 1'b0;
    chk("late_rsp_vld",   {31'b0, rsp_vld}, 32'd1);
    chk("late_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("late_rsp_rdata", rsp_rdata,        exp_rd);
`endif
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    chk("final_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("final_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
